// File: rtl/pipe_mem_stage.sv
// MEM stage with a req/ack data-memory bus, byte-lane steering and load extension.
// Define PIPE_MEM_ALIGN_CHECK_EN to raise misaligned half/word access exceptions.
module pipe_mem_stage #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              in_rena,
  input  logic              in_wena,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [31:0]       in_wdata,
  input  logic [31:0]       in_result,
  input  logic [2:0]        load_select,
  input  logic              load_sign,
  input  logic [2:0]        store_select,
  input  logic [4:0]        in_rf_waddr,
  input  logic              in_rf_wena,
  output logic              stall_o,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              out_valid,
  output logic [31:0]       out_result,
  output logic [4:0]        out_rf_waddr,
  output logic              out_rf_wena,
  output logic              out_exc,
  output logic [1:0]        out_exc_code
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_REQ  = 1'b1;

  localparam logic [15:0] TO_LIM = 16'(TIMEOUT);

  localparam logic [1:0] EXC_LD  = 2'b01;
  localparam logic [1:0] EXC_ST  = 2'b10;
  localparam logic [1:0] EXC_BUS = 2'b11;

  logic [0:0]        state_q;
  logic [15:0]       cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        off_q;
  logic              we_q;
  logic [3:0]        be_q;
  logic [31:0]       wdata_q;
  logic [2:0]        ld_sel_q;
  logic              ld_sign_q;
  logic [31:0]       res_q;
  logic [4:0]        waddr_q;
  logic              wena_q;

  logic        idle;
  logic        req;
  logic        mem_op;
  logic [2:0]  size;
  logic        is_byte;
  logic        is_half;
  logic        misal;
  logic        start;
  logic        to_hit;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  assign idle   = (state_q == S_IDLE);
  assign req    = (state_q == S_REQ);
  assign mem_op = in_valid & (in_rena | in_wena);
  assign size   = in_wena ? store_select : load_select;

  assign is_byte = (size == 3'd2);
  assign is_half = (size == 3'd1);

`ifdef PIPE_MEM_ALIGN_CHECK_EN
  assign misal = mem_op &
                 ((is_half & in_addr[0]) |
                  (!is_half & !is_byte & (in_addr[1:0] != 2'b00)));
`else
  assign misal = 1'b0;
`endif

  assign start = mem_op & !misal;

  // The limit cycle counts as the last request cycle; an ack there still wins.
  assign to_hit = req & !mem_ack & ((cnt_q + 16'd1) == TO_LIM);

  assign stall_o = rst_n &
                   ((idle & start) | (req & !mem_ack & !to_hit));

  assign mem_req   = req;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_be    = be_q;
  assign mem_wdata = wdata_q;

  always_comb begin
    be_d    = 4'b1111;
    wdata_d = in_wdata;
    unique case (1'b1)
      is_byte: begin
        be_d    = 4'b0001 << in_addr[1:0];
        wdata_d = {4{in_wdata[7:0]}};
      end
      is_half: begin
        be_d    = in_addr[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{in_wdata[15:0]}};
      end
      default: begin
        be_d    = 4'b1111;
        wdata_d = in_wdata;
      end
    endcase
  end

  always_comb begin
    ld_byte = 8'h00;
    unique case (off_q)
      2'd0:    ld_byte = mem_rdata[7:0];
      2'd1:    ld_byte = mem_rdata[15:8];
      2'd2:    ld_byte = mem_rdata[23:16];
      default: ld_byte = mem_rdata[31:24];
    endcase
    ld_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    ld_data = mem_rdata;
    unique case (1'b1)
      (ld_sel_q == 3'd2):
        ld_data = {{24{ld_sign_q & ld_byte[7]}}, ld_byte};
      (ld_sel_q == 3'd1):
        ld_data = {{16{ld_sign_q & ld_half[15]}}, ld_half};
      default:
        ld_data = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      off_q        <= '0;
      we_q         <= 1'b0;
      be_q         <= '0;
      wdata_q      <= '0;
      ld_sel_q     <= '0;
      ld_sign_q    <= 1'b0;
      res_q        <= '0;
      waddr_q      <= '0;
      wena_q       <= 1'b0;
      out_valid    <= 1'b0;
      out_result   <= '0;
      out_rf_waddr <= '0;
      out_rf_wena  <= 1'b0;
      out_exc      <= 1'b0;
      out_exc_code <= '0;
    end else begin
      out_valid    <= 1'b0;
      out_exc      <= 1'b0;
      out_exc_code <= 2'b00;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q   <= S_REQ;
            cnt_q     <= '0;
            addr_q    <= {in_addr[ADDR_W-1:2], 2'b00};
            off_q     <= in_addr[1:0];
            we_q      <= in_wena;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            ld_sel_q  <= load_select;
            ld_sign_q <= load_sign;
            res_q     <= in_result;
            waddr_q   <= in_rf_waddr;
            wena_q    <= in_rf_wena;
          end else if (misal) begin
            out_valid    <= 1'b1;
            out_result   <= in_result;
            out_rf_waddr <= in_rf_waddr;
            out_rf_wena  <= 1'b0;
            out_exc      <= 1'b1;
            out_exc_code <= in_wena ? EXC_ST : EXC_LD;
          end else begin
            out_valid    <= in_valid;
            out_result   <= in_result;
            out_rf_waddr <= in_rf_waddr;
            out_rf_wena  <= in_rf_wena;
          end
        end
        default: begin
          if (mem_ack) begin
            state_q      <= S_IDLE;
            out_valid    <= 1'b1;
            out_result   <= we_q ? res_q : ld_data;
            out_rf_waddr <= waddr_q;
            out_rf_wena  <= wena_q;
          end else if (to_hit) begin
            state_q      <= S_IDLE;
            out_valid    <= 1'b1;
            out_result   <= res_q;
            out_rf_waddr <= waddr_q;
            out_rf_wena  <= 1'b0;
            out_exc      <= 1'b1;
            out_exc_code <= EXC_BUS;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_mem_stage.sv
// Directed self-checking bench for pipe_mem_stage (TIMEOUT=8).
// Each memory transaction is driven by mem_txn and its observations checked after.
module tb_pipe_mem_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_rena;
  logic        in_wena;
  logic [31:0] in_addr;
  logic [31:0] in_wdata;
  logic [31:0] in_result;
  logic [2:0]  load_select;
  logic        load_sign;
  logic [2:0]  store_select;
  logic [4:0]  in_rf_waddr;
  logic        in_rf_wena;
  logic        stall_o;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        out_valid;
  logic [31:0] out_result;
  logic [4:0]  out_rf_waddr;
  logic        out_rf_wena;
  logic        out_exc;
  logic [1:0]  out_exc_code;

  int n_run;
  int n_fail;

  int          r_stalls;
  int          r_reqs;
  int          r_valids;
  int          r_lat;
  logic [31:0] r_res;
  logic [31:0] r_addr;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;
  logic        r_we;
  logic        r_exc;
  logic [1:0]  r_code;
  logic        r_wena;

  pipe_mem_stage #(.ADDR_W(32), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_rena(in_rena), .in_wena(in_wena),
    .in_addr(in_addr), .in_wdata(in_wdata), .in_result(in_result),
    .load_select(load_select), .load_sign(load_sign),
    .store_select(store_select),
    .in_rf_waddr(in_rf_waddr), .in_rf_wena(in_rf_wena),
    .stall_o(stall_o), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_result(out_result),
    .out_rf_waddr(out_rf_waddr), .out_rf_wena(out_rf_wena),
    .out_exc(out_exc), .out_exc_code(out_exc_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0;
    in_rena  = 1'b0;
    in_wena  = 1'b0;
    mem_ack  = 1'b0;
  endtask

  // Called at posedge+1; ack asserted in cycle ack_at (0 = op cycle), -1 never.
  task automatic mem_txn(input logic we, input logic [31:0] addr,
                         input logic [31:0] data, input logic [2:0] sel,
                         input logic sign, input logic [31:0] rdata,
                         input int ack_at, input int ncyc);
    bit done;
    done     = 1'b0;
    r_stalls = 0;
    r_reqs   = 0;
    r_valids = 0;
    r_lat    = -1;
    r_res    = '0;
    r_addr   = '0;
    r_be     = '0;
    r_wdata  = '0;
    r_we     = 1'b0;
    r_exc    = 1'b0;
    r_code   = '0;
    r_wena   = 1'b0;
    in_valid     = 1'b1;
    in_rena      = !we;
    in_wena      = we;
    in_addr      = addr;
    in_wdata     = data;
    in_result    = 32'h5A5A0001;
    load_select  = sel;
    store_select = sel;
    load_sign    = sign;
    in_rf_waddr  = 5'd5;
    in_rf_wena   = !we;
    for (int c = 0; c < ncyc; c++) begin
      if (done) begin
        in_valid = 1'b0;
        in_rena  = 1'b0;
        in_wena  = 1'b0;
      end
      mem_ack   = (c == ack_at);
      mem_rdata = rdata;
      #1;
      if (stall_o) r_stalls++;
      if (mem_req) begin
        r_reqs++;
        r_addr  = mem_addr;
        r_be    = mem_be;
        r_wdata = mem_wdata;
        r_we    = mem_we;
      end
      @(posedge clk);
      #1;
      if (out_valid) begin
        r_valids++;
        r_lat  = c + 1;
        r_res  = out_result;
        r_exc  = out_exc;
        r_code = out_exc_code;
        r_wena = out_rf_wena;
        done   = 1'b1;
      end
    end
    idle_inputs();
  endtask

  initial begin
    n_run  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    idle_inputs();
    in_addr      = '0;
    in_wdata     = '0;
    in_result    = '0;
    load_select  = '0;
    load_sign    = 1'b0;
    store_select = '0;
    in_rf_waddr  = '0;
    in_rf_wena   = 1'b0;
    mem_rdata    = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_stall", 32'(stall_o), 32'd0);
    chk("rst_result", out_result, 32'd0);
    chk("rst_be", 32'(mem_be), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // non-memory op: pass-through, 1-cycle latency, no stall
    in_valid    = 1'b1;
    in_result   = 32'h13572468;
    in_rf_waddr = 5'd9;
    in_rf_wena  = 1'b1;
    #1;
    chk("alu_stall", 32'(stall_o), 32'd0);
    @(posedge clk);
    #1;
    chk("alu_valid", 32'(out_valid), 32'd1);
    chk("alu_result", out_result, 32'h13572468);
    chk("alu_waddr", 32'(out_rf_waddr), 32'd9);
    chk("alu_wena", 32'(out_rf_wena), 32'd1);
    idle_inputs();
    @(posedge clk);
    #1;
    chk("bubble_valid", 32'(out_valid), 32'd0);

    // sw 0xDEADBEEF @0x100, ack 3 cycles after req
    mem_txn(1'b1, 32'h100, 32'hDEADBEEF, 3'd0, 1'b0, 32'h0, 3, 8);
    chk("sw_stall", 32'(r_stalls), 32'd3);
    chk("sw_reqs", 32'(r_reqs), 32'd3);
    chk("sw_be", 32'(r_be), 32'hF);
    chk("sw_addr", r_addr, 32'h100);
    chk("sw_wdata", r_wdata, 32'hDEADBEEF);
    chk("sw_we", 32'(r_we), 32'd1);
    chk("sw_valids", 32'(r_valids), 32'd1);
    chk("sw_lat", 32'(r_lat), 32'd4);
    chk("sw_result", r_res, 32'h5A5A0001);
    chk("sw_wena", 32'(r_wena), 32'd0);

    // lb @0x103, signed and unsigned
    mem_txn(1'b0, 32'h103, 32'h0, 3'd2, 1'b1, 32'h80FF0000, 1, 5);
    chk("lbs_result", r_res, 32'hFFFFFF80);
    chk("lbs_addr", r_addr, 32'h100);
    chk("lbs_we", 32'(r_we), 32'd0);
    chk("lbs_wena", 32'(r_wena), 32'd1);
    chk("lbs_lat", 32'(r_lat), 32'd2);
    mem_txn(1'b0, 32'h103, 32'h0, 3'd2, 1'b0, 32'h80FF0000, 1, 5);
    chk("lbu_result", r_res, 32'h00000080);

    // sh 0x1234 @0x102, then lh @0x102
    mem_txn(1'b1, 32'h102, 32'h00001234, 3'd1, 1'b0, 32'h0, 2, 6);
    chk("sh_wdata", r_wdata, 32'h12341234);
    chk("sh_be", 32'(r_be), 32'hC);
    chk("sh_addr", r_addr, 32'h100);
    chk("sh_stall", 32'(r_stalls), 32'd2);
    mem_txn(1'b0, 32'h102, 32'h0, 3'd1, 1'b1, 32'hBEEF0000, 2, 6);
    chk("lh_result", r_res, 32'hFFFFBEEF);

    // sb 0xA5 @0x201 lanes
    mem_txn(1'b1, 32'h201, 32'h000000A5, 3'd2, 1'b0, 32'h0, 1, 5);
    chk("sb_be", 32'(r_be), 32'h2);
    chk("sb_wdata", r_wdata, 32'hA5A5A5A5);

    // lw @0x101
    mem_txn(1'b0, 32'h101, 32'h0, 3'd0, 1'b0, 32'hCAFEF00D, 1, 5);
`ifdef PIPE_MEM_ALIGN_CHECK_EN
    chk("mis_reqs", 32'(r_reqs), 32'd0);
    chk("mis_stall", 32'(r_stalls), 32'd0);
    chk("mis_exc", 32'(r_exc), 32'd1);
    chk("mis_code", 32'(r_code), 32'd1);
    chk("mis_wena", 32'(r_wena), 32'd0);
    chk("mis_lat", 32'(r_lat), 32'd1);
`else
    chk("mis_addr", r_addr, 32'h100);
    chk("mis_result", r_res, 32'hCAFEF00D);
    chk("mis_exc", 32'(r_exc), 32'd0);
    chk("mis_lat", 32'(r_lat), 32'd2);
`endif

    // bus timeout: ack never arrives
    mem_txn(1'b0, 32'h300, 32'h0, 3'd0, 1'b0, 32'h0, -1, 14);
    chk("to_reqs", 32'(r_reqs), 32'd8);
    chk("to_valids", 32'(r_valids), 32'd1);
    chk("to_exc", 32'(r_exc), 32'd1);
    chk("to_code", 32'(r_code), 32'd3);
    chk("to_wena", 32'(r_wena), 32'd0);
    chk("to_lat", 32'(r_lat), 32'd9);
    chk("to_idle_req", 32'(mem_req), 32'd0);
    chk("to_idle_stall", 32'(stall_o), 32'd0);

    // ack on the 8th request cycle retires normally
    mem_txn(1'b0, 32'h200, 32'h0, 3'd0, 1'b0, 32'h01234567, 8, 14);
    chk("ack8_reqs", 32'(r_reqs), 32'd8);
    chk("ack8_exc", 32'(r_exc), 32'd0);
    chk("ack8_valids", 32'(r_valids), 32'd1);
    chk("ack8_result", r_res, 32'h01234567);
    chk("ack8_lat", 32'(r_lat), 32'd9);

    // reset asserted while a request is outstanding
    in_valid     = 1'b1;
    in_rena      = 1'b0;
    in_wena      = 1'b1;
    in_addr      = 32'h400;
    in_wdata     = 32'h11111111;
    store_select = 3'd0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("pre_rst_req", 32'(mem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_req", 32'(mem_req), 32'd0);
    chk("arst_stall", 32'(stall_o), 32'd0);
    chk("arst_result", out_result, 32'd0);
    chk("arst_valid", 32'(out_valid), 32'd0);
    idle_inputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    mem_txn(1'b0, 32'h104, 32'h0, 3'd0, 1'b0, 32'h0BADCAFE, 2, 6);
    chk("post_result", r_res, 32'h0BADCAFE);
    chk("post_addr", r_addr, 32'h104);
    chk("post_lat", 32'(r_lat), 32'd3);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_mem_stage.md
# pipe_mem_stage

Parametrised MEM-stage successor for the static pipeline CPU. It replaces the single-cycle internal data memory with a request/acknowledge bus to an external data memory of arbitrary latency. It generates store byte lanes and extracts and extends load data. It stalls upstream stages while an access is outstanding, flags misalignment and bus timeouts, and registers its results into the MEM/WB boundary.

## Interface
Parameters:
- `ADDR_W`, 32: data address width.
- `TIMEOUT`, 255: maximum cycles waiting for `mem_ack`. Must be 1..2^16-1.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  the EXE/MEM register holds a live instruction.
- `in_rena` / `in_wena`  in  1  load / store. Never both high.
- `in_addr`  in  ADDR_W  byte address.
- `in_wdata`  in  32  store data (rt).
- `in_result`  in  32  non-memory result, passed through.
- `load_select`  in  3  0 word, 1 half, 2 byte; other values are treated as word.
- `load_sign`  in  1  1 sign-extend, 0 zero-extend.
- `store_select`  in  3  same encoding as `load_select`.
- `in_rf_waddr`  in  5  destination register.
- `in_rf_wena`  in  1  register-file write enable.
- `stall_o`  out  1  freeze PC, IF, ID and EXE stages.
- `mem_req`  out  1  bus request.
- `mem_we`  out  1  1 for write.
- `mem_addr`  out  ADDR_W  word-aligned address; bits [1:0] are always 0.
- `mem_be`  out  4  byte enables.
- `mem_wdata`  out  32  lane-replicated store data.
- `mem_ack`  in  1  single-cycle acknowledge.
- `mem_rdata`  in  32  read word; valid in the `mem_ack` cycle.
- `out_valid`  out  1  instruction retired into MEM/WB this cycle.
- `out_result`  out  32  load data or passed-through result.
- `out_rf_waddr`  out  5  registered destination register.
- `out_rf_wena`  out  1  registered write enable.
- `out_exc`  out  1  exception flag.
- `out_exc_code`  out  2  01 misaligned load, 10 misaligned store, 11 bus timeout.

## Operation
- FSM states: IDLE and REQ.
- A memory op is `in_valid & (in_rena | in_wena)`.
- IDLE, memory op, aligned: latch the request, go to REQ, assert `stall_o`.
- IDLE, non-memory op: register `in_result`, `in_rf_waddr` and `in_rf_wena` to the outputs and set `out_valid` = `in_valid`.
- REQ: hold `mem_req`=1 with `mem_addr`, `mem_we`, `mem_be` and `mem_wdata` stable until `mem_ack`.
- REQ, on `mem_ack`:
  - For a load, `out_result` = the extracted load data. For a store, `out_result` = `in_result`.
  - `out_valid` = 1; return to IDLE.
- `stall_o` = (IDLE & aligned memory op) | (REQ & !`mem_ack`). It is combinational, so upstream stages advance on the ack cycle.
- Store lanes (little-endian):
  - Byte: wdata = {4{b}}, be = 1 << addr[1:0].
  - Half: wdata = {2{h}}, be = addr[1] ? 1100 : 0011.
  - Word: be = 1111.
- Load extraction:
  - Byte = `mem_rdata`[8·addr[1:0] +: 8].
  - Half = addr[1] ? [31:16] : [15:0].
  - The selected field is extended per `load_sign`.
- Timeout:
  - A 16-bit counter clears on entry to REQ and increments each REQ cycle without ack.
  - When it reaches `TIMEOUT`, drop `mem_req`, retire with `out_exc`=1, code 11, `out_rf_wena`=0, and return to IDLE.
  - An ack arriving in the same cycle as the limit wins; no exception is raised.
- Every exception retirement forces `out_rf_wena`=0.
- While stalled (no ack), `out_valid`=0; the bubble is a NOP into WB.

## Timing
- Reset values: state IDLE, counter 0, `mem_req` 0, and every registered output 0. Combinational outputs follow from state.
- Reset asserted mid-REQ aborts the access: `mem_req` falls asynchronously and no retirement occurs.
- Non-memory op and misaligned op: latency 1 cycle, no stall.
- Memory op acked N cycles after the request rises (N≥1):
  - `stall_o` is high for N cycles.
  - Outputs update at the edge ending the ack cycle, so total latency is N+1.
- Only one request is ever outstanding.
- `mem_ack` while in IDLE is ignored.

## Configuration
- `PIPE_MEM_ALIGN_CHECK_EN` defined:
  - A half access with addr[0]=1, or a word access with addr[1:0]≠0, issues no request.
  - It retires with `out_exc`=1, code 01 (load) or 10 (store), in 1 cycle.
- `PIPE_MEM_ALIGN_CHECK_EN` undefined:
  - No misalignment exception.
  - Half lane selection ignores addr[0]; word ignores addr[1:0].
  - Codes 01 and 10 never occur.

## Test plan
- sw 0xDEADBEEF @0x100, ack 3 cycles after req -> `mem_be`=1111, `mem_addr`=0x100, `stall_o` high 3 cycles, `out_valid` pulses once.
- lb @0x103, `mem_rdata`=0x80FF0000, `load_sign`=1 -> `out_result`=0xFFFFFF80. Repeat with `load_sign`=0 -> 0x00000080.
- sh 0x1234 @0x102 -> `mem_wdata`=0x12341234, `mem_be`=1100. lh @0x102 with rdata 0xBEEF0000, `load_sign`=1 -> 0xFFFFBEEF.
- Macro defined, lw @0x101 -> `mem_req` stays 0, `out_exc`=1, code 01, `out_rf_wena`=0, 1-cycle latency. Macro undefined -> reads 0x100 normally.
- `TIMEOUT`=8, ack never arrives -> `mem_req` high exactly 8 cycles, then `out_exc`=1, code 11, FSM in IDLE. Separately, an ack on cycle 8 retires normally.
- `rst_n` low during REQ -> `mem_req`, `stall_o` and all outputs go to 0 immediately. After release, the next op behaves normally.
